// File: rtl/uart_cmd_frame_master.sv
// ---------------------------------------------------------------------------
// uart_cmd_frame_master
//
// Host-side initiator for the UART command protocol. Accepts one command
// request, serialises it into its byte frame towards a UART transmitter,
// then collects the response bytes from a UART receiver and reports the
// result (or a timeout if the response does not arrive in time).
//
// Ports
//   clk, reset        : single clock, asynchronous active-high reset
//   cmd_*_in/out      : command request handshake and fields
//   tx_byte_out/valid : frame byte to the transmitter (valid/ready handshake)
//   tx_ready_in       : transmitter accepts the presented byte
//   rx_byte_in/valid  : received byte, one-cycle pulse per byte
//   rsp_data_out      : last completed result (held until next completion)
//   rsp_valid_out     : one-cycle completion pulse
//   rsp_timeout_out   : one-cycle timeout pulse
//   busy_out          : command in progress
//
// State table
//   state      | meaning
//   S_IDLE     | ready for a command, stray rx bytes dropped
//   S_SEND     | presenting frame bytes to the transmitter
//   S_WAIT_RSP | collecting response bytes, timeout counter running
// ---------------------------------------------------------------------------
module uart_cmd_frame_master #(
    parameter int WIDTH       = 8,
    parameter int ADDR        = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid_in,
    output logic               cmd_ready_out,
    input  logic [1:0]         cmd_type_in,
    input  logic [ADDR-1:0]    cmd_addr_in,
    input  logic [WIDTH-1:0]   cmd_data_a_in,
    input  logic [WIDTH-1:0]   cmd_data_b_in,
    input  logic [3:0]         cmd_fun_in,
    output logic [WIDTH-1:0]   tx_byte_out,
    output logic               tx_valid_out,
    input  logic               tx_ready_in,
    input  logic [WIDTH-1:0]   rx_byte_in,
    input  logic               rx_valid_in,
    output logic [2*WIDTH-1:0] rsp_data_out,
    output logic               rsp_valid_out,
    output logic               rsp_timeout_out,
    output logic               busy_out
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] T_RF_WR   = 2'd0;
    localparam logic [1:0] T_RF_RD   = 2'd1;
    localparam logic [1:0] T_ALU_OP  = 2'd2;
    localparam logic [1:0] T_ALU_NOP = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_SEND     = 2'd1,
        S_WAIT_RSP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         type_q, type_d;
    logic [ADDR-1:0]    addr_q, addr_d;
    logic [WIDTH-1:0]   data_a_q, data_a_d;
    logic [WIDTH-1:0]   data_b_q, data_b_d;
    logic [3:0]         fun_q, fun_d;
    logic [1:0]         byte_cnt_q, byte_cnt_d;
    logic [WIDTH-1:0]   tx_byte_q, tx_byte_d;
    logic               tx_valid_q, tx_valid_d;
    logic               rsp_cnt_q, rsp_cnt_d;
    logic [WIDTH-1:0]   rsp_lo_q, rsp_lo_d;
    logic [TW-1:0]      to_cnt_q, to_cnt_d;
    logic [2*WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic               rsp_timeout_q, rsp_timeout_d;

    // Byte idx of the frame for a given command type; header at idx 0.
    function automatic logic [WIDTH-1:0] frame_byte(
        input logic [1:0]       typ,
        input logic [1:0]       idx,
        input logic [ADDR-1:0]  addr,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic [3:0]       fun
    );
        logic [WIDTH-1:0] b_out;
        b_out = '0;
        case (typ)
            T_RF_WR: begin
                case (idx)
                    2'd0:    b_out = WIDTH'(8'hAA);
                    2'd1:    b_out = WIDTH'(addr);
                    2'd2:    b_out = a;
                    default: b_out = '0;
                endcase
            end
            T_RF_RD: begin
                case (idx)
                    2'd0:    b_out = WIDTH'(8'hBB);
                    2'd1:    b_out = WIDTH'(addr);
                    default: b_out = '0;
                endcase
            end
            T_ALU_OP: begin
                case (idx)
                    2'd0:    b_out = WIDTH'(8'hCC);
                    2'd1:    b_out = a;
                    2'd2:    b_out = b;
                    default: b_out = WIDTH'(fun);
                endcase
            end
            default: begin
                case (idx)
                    2'd0:    b_out = WIDTH'(8'hDD);
                    2'd1:    b_out = WIDTH'(fun);
                    default: b_out = '0;
                endcase
            end
        endcase
        return b_out;
    endfunction

    function automatic logic [1:0] last_idx(input logic [1:0] typ);
        case (typ)
            T_RF_WR:  return 2'd2;
            T_RF_RD:  return 2'd1;
            T_ALU_OP: return 2'd3;
            default:  return 2'd1;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            type_q        <= '0;
            addr_q        <= '0;
            data_a_q      <= '0;
            data_b_q      <= '0;
            fun_q         <= '0;
            byte_cnt_q    <= '0;
            tx_byte_q     <= '0;
            tx_valid_q    <= 1'b0;
            rsp_cnt_q     <= 1'b0;
            rsp_lo_q      <= '0;
            to_cnt_q      <= '0;
            rsp_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            type_q        <= type_d;
            addr_q        <= addr_d;
            data_a_q      <= data_a_d;
            data_b_q      <= data_b_d;
            fun_q         <= fun_d;
            byte_cnt_q    <= byte_cnt_d;
            tx_byte_q     <= tx_byte_d;
            tx_valid_q    <= tx_valid_d;
            rsp_cnt_q     <= rsp_cnt_d;
            rsp_lo_q      <= rsp_lo_d;
            to_cnt_q      <= to_cnt_d;
            rsp_data_q    <= rsp_data_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        type_d        = type_q;
        addr_d        = addr_q;
        data_a_d      = data_a_q;
        data_b_d      = data_b_q;
        fun_d         = fun_q;
        byte_cnt_d    = byte_cnt_q;
        tx_byte_d     = tx_byte_q;
        tx_valid_d    = tx_valid_q;
        rsp_cnt_d     = rsp_cnt_q;
        rsp_lo_d      = rsp_lo_q;
        to_cnt_d      = to_cnt_q;
        rsp_data_d    = rsp_data_q;
        rsp_valid_d   = 1'b0;
        rsp_timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_in) begin
                    type_d     = cmd_type_in;
                    addr_d     = cmd_addr_in;
                    data_a_d   = cmd_data_a_in;
                    data_b_d   = cmd_data_b_in;
                    fun_d      = cmd_fun_in;
                    byte_cnt_d = 2'd0;
                    tx_byte_d  = frame_byte(cmd_type_in, 2'd0, cmd_addr_in,
                                            cmd_data_a_in, cmd_data_b_in, cmd_fun_in);
                    tx_valid_d = 1'b1;
                    state_d    = S_SEND;
                end
            end

            S_SEND: begin
                if (tx_ready_in) begin
                    if (byte_cnt_q == last_idx(type_q)) begin
                        tx_valid_d = 1'b0;
                        tx_byte_d  = '0;
                        if (type_q == T_RF_WR) begin
                            // Writes carry no response: complete right away.
                            rsp_data_d  = '0;
                            rsp_valid_d = 1'b1;
                            state_d     = S_IDLE;
                        end else begin
                            rsp_cnt_d = 1'b0;
                            to_cnt_d  = '0;
                            state_d   = S_WAIT_RSP;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        tx_byte_d  = frame_byte(type_q, byte_cnt_q + 2'd1, addr_q,
                                                data_a_q, data_b_q, fun_q);
                    end
                end
            end

            S_WAIT_RSP: begin
                // RF_RD needs one byte (slot 0); ALU commands need two (slot 1 last).
                if (rx_valid_in && (rsp_cnt_q == (type_q != T_RF_RD))) begin
                    // A completing byte beats a simultaneous timeout.
                    if (type_q == T_RF_RD) begin
                        rsp_data_d = {{WIDTH{1'b0}}, rx_byte_in};
                    end else begin
                        rsp_data_d = {rx_byte_in, rsp_lo_q};
                    end
                    rsp_valid_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    if (rx_valid_in) begin
                        rsp_lo_d  = rx_byte_in;
                        rsp_cnt_d = 1'b1;
                    end
                    if (to_cnt_q == TO_LAST) begin
                        rsp_timeout_d = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end
            end

            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    assign cmd_ready_out   = (state_q == S_IDLE);
    assign busy_out        = (state_q != S_IDLE);
    assign tx_byte_out     = tx_byte_q;
    assign tx_valid_out    = tx_valid_q;
    assign rsp_data_out    = rsp_data_q;
    assign rsp_valid_out   = rsp_valid_q;
    assign rsp_timeout_out = rsp_timeout_q;

endmodule

// File: tb/tb_uart_cmd_frame_master.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_frame_master
//
// Directed bench for uart_cmd_frame_master. Expected frame bytes and
// expected results are queued when each command is issued and popped as
// the DUT presents bytes and completion pulses.
// ---------------------------------------------------------------------------
module tb_uart_cmd_frame_master;

    localparam int WIDTH = 8;
    localparam int ADDR  = 4;
    localparam int TOC   = 16;

    logic               clk;
    logic               reset;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [1:0]         cmd_type;
    logic [ADDR-1:0]    cmd_addr;
    logic [WIDTH-1:0]   cmd_a;
    logic [WIDTH-1:0]   cmd_b;
    logic [3:0]         cmd_fun;
    logic [WIDTH-1:0]   tx_byte;
    logic               tx_valid;
    logic               tx_ready;
    logic [WIDTH-1:0]   rx_byte;
    logic               rx_valid;
    logic [2*WIDTH-1:0] rsp_data;
    logic               rsp_valid;
    logic               rsp_timeout;
    logic               busy;

    int n_checks = 0;
    int n_err    = 0;

    logic [WIDTH-1:0]   tx_q[$];
    logic [2*WIDTH-1:0] rsp_q[$];
    logic [2*WIDTH-1:0] last_rsp;

    uart_cmd_frame_master #(
        .WIDTH(WIDTH), .ADDR(ADDR), .TIMEOUT_CYC(TOC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .cmd_valid_in(cmd_valid),
        .cmd_ready_out(cmd_ready),
        .cmd_type_in(cmd_type),
        .cmd_addr_in(cmd_addr),
        .cmd_data_a_in(cmd_a),
        .cmd_data_b_in(cmd_b),
        .cmd_fun_in(cmd_fun),
        .tx_byte_out(tx_byte),
        .tx_valid_out(tx_valid),
        .tx_ready_in(tx_ready),
        .rx_byte_in(rx_byte),
        .rx_valid_in(rx_valid),
        .rsp_data_out(rsp_data),
        .rsp_valid_out(rsp_valid),
        .rsp_timeout_out(rsp_timeout),
        .busy_out(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge while idle; returns at the negedge after the accept edge.
    task automatic issue(input logic [1:0] typ, input logic [3:0] addr,
                         input logic [7:0] a, input logic [7:0] b, input logic [3:0] fun,
                         input bit push_rsp, input logic [15:0] exp_rsp);
        chk("cmd_ready_before_accept", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_type  = typ;
        cmd_addr  = addr;
        cmd_a     = a;
        cmd_b     = b;
        cmd_fun   = fun;
        case (typ)
            2'd0: begin tx_q.push_back(8'hAA); tx_q.push_back({4'h0, addr}); tx_q.push_back(a); end
            2'd1: begin tx_q.push_back(8'hBB); tx_q.push_back({4'h0, addr}); end
            2'd2: begin tx_q.push_back(8'hCC); tx_q.push_back(a); tx_q.push_back(b);
                        tx_q.push_back({4'h0, fun}); end
            default: begin tx_q.push_back(8'hDD); tx_q.push_back({4'h0, fun}); end
        endcase
        if (push_rsp) rsp_q.push_back(exp_rsp);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_type  = 2'($urandom);
        cmd_addr  = 4'($urandom);
        cmd_a     = 8'($urandom);
        cmd_b     = 8'($urandom);
        cmd_fun   = 4'($urandom);
        chk("tx_valid_after_accept", tx_valid, 1);
        chk("busy_after_accept", busy, 1);
        chk("cmd_ready_after_accept", cmd_ready, 0);
        chk("no_pulse_after_accept", {rsp_valid, rsp_timeout}, 0);
    endtask

    // Drains the expected frame; returns at the negedge after the last transfer.
    task automatic run_frame(input bit toggle, input bit stray);
        int cyc;
        bit r;
        cyc = 0;
        while (tx_q.size() > 0 && cyc < 40) begin
            r = toggle ? cyc[0] : 1'b1;
            chk("tx_valid_held", tx_valid, 1);
            chk("tx_byte", tx_byte, tx_q[0]);
            tx_ready = r;
            if (stray) begin
                rx_valid = 1'b1;
                rx_byte  = 8'($urandom);
            end
            if (r) void'(tx_q.pop_front());
            @(negedge clk);
            cyc++;
        end
        chk("frame_cycle_budget", tx_q.size(), 0);
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        chk("tx_valid_after_frame", tx_valid, 0);
    endtask

    task automatic rx_send(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    // Completion pulse is expected at the current negedge.
    task automatic check_rsp();
        logic [15:0] exp;
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_timeout_exclusive", rsp_timeout, 0);
        chk("cmd_ready_on_pulse", cmd_ready, 1);
        chk("busy_on_pulse", busy, 0);
        chk("rsp_q_nonempty", rsp_q.size() > 0, 1);
        if (rsp_q.size() > 0) begin
            exp = rsp_q.pop_front();
            chk("rsp_data", rsp_data, exp);
            last_rsp = exp;
        end
    endtask

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_type  = '0;
        cmd_addr  = '0;
        cmd_a     = '0;
        cmd_b     = '0;
        cmd_fun   = '0;
        tx_ready  = 1'b0;
        rx_byte   = '0;
        rx_valid  = 1'b0;
        last_rsp  = '0;

        @(negedge clk);
        chk("rst_tx_byte", tx_byte, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        @(negedge clk);

        // Stray rx bytes while idle must be dropped.
        rx_send(8'h11);
        rx_send(8'h22);
        chk("idle_stray_busy", busy, 0);
        chk("idle_stray_no_pulse", {rsp_valid, rsp_timeout}, 0);

        // RF_WR: no response bytes, completion right after the last transfer.
        issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b1, 16'h0000);
        run_frame(1'b0, 1'b0);
        check_rsp();

        // RF_RD issued back-to-back in the pulse cycle.
        issue(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1'b1, 16'h007E);
        run_frame(1'b0, 1'b0);
        rx_send(8'h7E);
        check_rsp();

        // ALU_OP with a stalling transmitter.
        @(negedge clk);
        issue(2'd2, 4'h0, 8'h12, 8'h34, 4'h0, 1'b1, 16'h0046);
        run_frame(1'b1, 1'b0);
        rx_send(8'h46);
        chk("partial_rsp_no_pulse", {rsp_valid, rsp_timeout}, 0);
        chk("partial_rsp_busy", busy, 1);
        rx_send(8'h00);
        check_rsp();

        // ALU_NOP with no response: timeout after TOC cycles in WAIT_RSP.
        @(negedge clk);
        issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h3, 1'b0, 16'h0000);
        run_frame(1'b0, 1'b0);
        for (int i = 1; i <= TOC; i++) begin
            @(negedge clk);
            if (i < TOC) begin
                chk("timeout_not_early", {rsp_valid, rsp_timeout}, 0);
                chk("busy_while_waiting", busy, 1);
            end
        end
        chk("rsp_timeout", rsp_timeout, 1);
        chk("timeout_no_valid", rsp_valid, 0);
        chk("timeout_rsp_data_kept", rsp_data, last_rsp);
        chk("cmd_ready_on_timeout", cmd_ready, 1);
        @(negedge clk);
        chk("timeout_one_cycle", rsp_timeout, 0);

        // ALU_NOP with stray rx bytes during SEND; only later bytes count.
        issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h5, 1'b1, 16'h0201);
        run_frame(1'b0, 1'b1);
        chk("stray_send_busy", busy, 1);
        rx_send(8'h01);
        chk("stray_partial_no_pulse", {rsp_valid, rsp_timeout}, 0);
        rx_send(8'h02);
        check_rsp();

        // Reset in the middle of an ALU_OP frame.
        @(negedge clk);
        issue(2'd2, 4'h0, 8'hA1, 8'hB2, 4'h7, 1'b0, 16'h0000);
        tx_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("pre_reset_tx_byte", tx_byte, tx_q.pop_front());
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        chk("mid_reset_tx_valid", tx_valid, 0);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_cmd_ready", cmd_ready, 1);
        chk("mid_reset_rsp_data", rsp_data, 0);
        chk("mid_reset_no_pulse", {rsp_valid, rsp_timeout}, 0);
        tx_ready = 1'b0;
        tx_q.delete();
        last_rsp = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_reset_no_pulse", {rsp_valid, rsp_timeout, busy}, 0);
        end

        // Recovery: RF_RD after reset.
        issue(2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 1'b1, 16'h00A5);
        run_frame(1'b0, 1'b0);
        rx_send(8'hA5);
        check_rsp();
        @(negedge clk);
        chk("final_pulse_one_cycle", rsp_valid, 0);
        chk("final_rsp_data_held", rsp_data, 16'h00A5);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
